// File: rtl/trap_sequencer.sv
// Trap/MRET sequencer: captures the oldest exception or MRET, flushes one cycle, then holds a redirect.
// Optional mtval CSR is built only when TRAP_SEQUENCER_MTVAL_EN is defined.
`ifndef XLEN_64b
`define XLEN_64b 2'b10
`endif

module trap_sequencer #(
  parameter logic [1:0] XLEN = `XLEN_64b,
  localparam int W = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_exc_valid_f,
  input  logic [3:0]   i_exc_code_f,
  input  logic [W-1:0] i_pc_f,
  input  logic         i_exc_valid_e,
  input  logic [3:0]   i_exc_code_e,
  input  logic [W-1:0] i_pc_e,
  input  logic [W-1:0] i_addr_e,
  input  logic         i_mret_e,
  input  logic [W-1:0] i_mtvec,
  input  logic         i_redirect_ready,
  output logic         o_flush,
  output logic         o_stall,
  output logic         o_redirect_valid,
  output logic [W-1:0] o_redirect_pc,
  output logic [1:0]   o_current_privilege,
  output logic [W-1:0] o_mepc,
  output logic [W-1:0] o_mcause,
  output logic [W-1:0] o_mtval,
  output logic [1:0]   o_dbg_state
);

  // Redirect handshake: o_redirect_valid and o_redirect_pc stay constant until the
  // cycle with i_redirect_ready=1; the transfer completes on that rising edge.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   priv_q, priv_d;
  logic [1:0]   mpp_q, mpp_d;
  logic [W-1:0] mepc_q, mepc_d;
  logic [W-1:0] mcause_q, mcause_d;
  logic [W-1:0] target_q, target_d;
  logic         take_trap;
  logic [3:0]   trap_code;
  logic [W-1:0] trap_pc;
`ifdef TRAP_SEQUENCER_MTVAL_EN
  logic [W-1:0] mtval_q, mtval_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      priv_q   <= 2'b11;
      mpp_q    <= 2'b00;
      mepc_q   <= '0;
      mcause_q <= '0;
      target_q <= '0;
`ifdef TRAP_SEQUENCER_MTVAL_EN
      mtval_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      priv_q   <= priv_d;
      mpp_q    <= mpp_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      target_q <= target_d;
`ifdef TRAP_SEQUENCER_MTVAL_EN
      mtval_q  <= mtval_d;
`endif
    end
  end

  always_comb begin
    state_d          = state_q;
    priv_d           = priv_q;
    mpp_d            = mpp_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    target_d         = target_q;
`ifdef TRAP_SEQUENCER_MTVAL_EN
    mtval_d          = mtval_q;
`endif
    take_trap        = 1'b0;
    trap_code        = 4'd0;
    trap_pc          = '0;
    o_flush          = 1'b0;
    o_stall          = 1'b0;
    o_redirect_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        // E is older than F, so it wins; MRET outside M-mode becomes an illegal-instruction trap.
        if (i_exc_valid_e) begin
          take_trap = 1'b1;
          trap_code = i_exc_code_e;
          trap_pc   = i_pc_e;
        end else if (i_mret_e) begin
          if (priv_q == 2'b11) begin
            priv_d   = mpp_q;
            mpp_d    = 2'b00;
            target_d = {mepc_q[W-1:2], 2'b00};
            state_d  = S_FLUSH;
          end else begin
            take_trap = 1'b1;
            trap_code = 4'd2;
            trap_pc   = i_pc_e;
          end
        end else if (i_exc_valid_f) begin
          take_trap = 1'b1;
          trap_code = i_exc_code_f;
          trap_pc   = i_pc_f;
        end

        if (take_trap) begin
          mcause_d = {{(W-4){1'b0}}, trap_code};
          mepc_d   = trap_pc;
          mpp_d    = priv_q;
          priv_d   = 2'b11;
          target_d = {i_mtvec[W-1:2], 2'b00};
          state_d  = S_FLUSH;
`ifdef TRAP_SEQUENCER_MTVAL_EN
          case (trap_code)
            4'd0, 4'd1:             mtval_d = trap_pc;
            4'd4, 4'd5, 4'd6, 4'd7: mtval_d = i_addr_e;
            default:                mtval_d = '0;
          endcase
`endif
        end
      end
      S_FLUSH: begin
        o_flush = 1'b1;
        o_stall = 1'b1;
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        o_stall          = 1'b1;
        o_redirect_valid = 1'b1;
        if (i_redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_redirect_pc       = o_redirect_valid ? target_q : '0;
  assign o_current_privilege = priv_q;
  assign o_mepc              = mepc_q;
  assign o_mcause            = mcause_q;
  assign o_dbg_state         = state_q;

`ifdef TRAP_SEQUENCER_MTVAL_EN
  assign o_mtval = mtval_q;
  logic unused_bits;
  assign unused_bits = ^i_mtvec[1:0];
`else
  assign o_mtval = '0;
  logic unused_bits;
  assign unused_bits = ^{i_mtvec[1:0], i_addr_e};
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected redirects go into a queue, a monitor checks each handshake.
module tb_trap_sequencer;
  localparam int W = 64;
`ifdef TRAP_SEQUENCER_MTVAL_EN
  localparam bit MTVAL_ON = 1'b1;
`else
  localparam bit MTVAL_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] mepc;
    logic [W-1:0] mcause;
    logic [W-1:0] mtval;
    logic [1:0]   priv;
  } exp_t;

  logic         i_clk, i_rst_n;
  logic         i_exc_valid_f, i_exc_valid_e, i_mret_e, i_redirect_ready;
  logic [3:0]   i_exc_code_f, i_exc_code_e;
  logic [W-1:0] i_pc_f, i_pc_e, i_addr_e, i_mtvec;
  logic         o_flush, o_stall, o_redirect_valid;
  logic [W-1:0] o_redirect_pc, o_mepc, o_mcause, o_mtval;
  logic [1:0]   o_current_privilege, o_dbg_state;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  trap_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_exc_valid_f(i_exc_valid_f), .i_exc_code_f(i_exc_code_f), .i_pc_f(i_pc_f),
    .i_exc_valid_e(i_exc_valid_e), .i_exc_code_e(i_exc_code_e), .i_pc_e(i_pc_e),
    .i_addr_e(i_addr_e), .i_mret_e(i_mret_e), .i_mtvec(i_mtvec),
    .i_redirect_ready(i_redirect_ready),
    .o_flush(o_flush), .o_stall(o_stall), .o_redirect_valid(o_redirect_valid),
    .o_redirect_pc(o_redirect_pc), .o_current_privilege(o_current_privilege),
    .o_mepc(o_mepc), .o_mcause(o_mcause), .o_mtval(o_mtval), .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] pc, input logic [W-1:0] mepc,
                              input logic [W-1:0] mcause, input logic [W-1:0] mtval,
                              input logic [1:0] priv);
    exp_t e;
    e.pc     = pc;
    e.mepc   = mepc;
    e.mcause = mcause;
    e.mtval  = MTVAL_ON ? mtval : '0;
    e.priv   = priv;
    return e;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_events();
    i_exc_valid_f = 1'b0;
    i_exc_valid_e = 1'b0;
    i_mret_e      = 1'b0;
  endtask

  // Event inputs are already driven; walk FLUSH and REDIRECT, optionally stalling the handshake.
  task automatic run_event(input exp_t e, input int hold_n, input bit inject);
    exp_q.push_back(e);
    tick();
    chk("flush_cycle_flush", {63'd0, o_flush}, 64'd1);
    chk("flush_cycle_stall", {63'd0, o_stall}, 64'd1);
    chk("flush_cycle_rv", {63'd0, o_redirect_valid}, 64'd0);
    chk("capture_mcause", o_mcause, e.mcause);
    chk("capture_priv", {62'd0, o_current_privilege}, {62'd0, e.priv});
    clear_events();
    tick();
    chk("redirect_rv", {63'd0, o_redirect_valid}, 64'd1);
    chk("redirect_flush", {63'd0, o_flush}, 64'd0);
    for (int i = 0; i < hold_n; i++) begin
      if (inject) begin
        i_exc_valid_e = 1'b1; i_exc_code_e = 4'd5; i_pc_e = 64'h9999;
        i_exc_valid_f = 1'b1; i_exc_code_f = 4'd1; i_pc_f = 64'h7777;
        i_mret_e      = 1'b1;
      end
      tick();
      chk("hold_pc", o_redirect_pc, e.pc);
      chk("hold_stall", {63'd0, o_stall}, 64'd1);
      chk("hold_rv", {63'd0, o_redirect_valid}, 64'd1);
      chk("hold_mepc", o_mepc, e.mepc);
      chk("hold_mcause", o_mcause, e.mcause);
      chk("hold_mtval", o_mtval, e.mtval);
      chk("hold_priv", {62'd0, o_current_privilege}, {62'd0, e.priv});
    end
    clear_events();
    i_redirect_ready = 1'b1;
    tick();
    i_redirect_ready = 1'b0;
    chk("idle_rv", {63'd0, o_redirect_valid}, 64'd0);
    chk("idle_stall", {63'd0, o_stall}, 64'd0);
    chk("idle_flush", {63'd0, o_flush}, 64'd0);
    chk("idle_state", {62'd0, o_dbg_state}, 64'd0);
  endtask

  // Scoreboard monitor: one expected entry per completed redirect handshake
  always @(negedge i_clk) begin
    if (i_rst_n && o_redirect_valid && i_redirect_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect: got pc 0x%0h expected no redirect", o_redirect_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_redirect_pc", o_redirect_pc, e.pc);
        chk("sb_mepc", o_mepc, e.mepc);
        chk("sb_mcause", o_mcause, e.mcause);
        chk("sb_mtval", o_mtval, e.mtval);
        chk("sb_priv", {62'd0, o_current_privilege}, {62'd0, e.priv});
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    clear_events();
    i_exc_code_f = '0; i_exc_code_e = '0;
    i_pc_f = '0; i_pc_e = '0; i_addr_e = '0; i_mtvec = '0;
    i_redirect_ready = 1'b0;
    repeat (2) tick();
    chk("rst_priv", {62'd0, o_current_privilege}, 64'd3);
    chk("rst_mepc", o_mepc, 64'd0);
    chk("rst_mcause", o_mcause, 64'd0);
    chk("rst_mtval", o_mtval, 64'd0);
    chk("rst_flush", {63'd0, o_flush}, 64'd0);
    chk("rst_stall", {63'd0, o_stall}, 64'd0);
    chk("rst_rv", {63'd0, o_redirect_valid}, 64'd0);
    chk("rst_rpc", o_redirect_pc, 64'd0);
    i_rst_n = 1'b1;
    repeat (2) tick();
    chk("quiet_state", {62'd0, o_dbg_state}, 64'd0);

    // MRET from M-mode with MPP=0 drops to U-mode
    i_mret_e = 1'b1;
    run_event(mk(64'h0, 64'h0, 64'd0, 64'h0, 2'b00), 0, 1'b0);

    // Load-address-misaligned style trap from priv 0
    i_exc_valid_e = 1'b1; i_exc_code_e = 4'd4; i_pc_e = 64'h1000;
    i_addr_e = 64'h2003; i_mtvec = 64'h8001;
    run_event(mk(64'h8000, 64'h1000, 64'd4, 64'h2003, 2'b11), 0, 1'b0);

    // Simultaneous E and F: E wins; then stalled redirect with injected events
    i_exc_valid_e = 1'b1; i_exc_code_e = 4'd11; i_pc_e = 64'h3000; i_addr_e = 64'h55;
    i_exc_valid_f = 1'b1; i_exc_code_f = 4'd0;  i_pc_f = 64'h4000;
    run_event(mk(64'h8000, 64'h3000, 64'd11, 64'h0, 2'b11), 5, 1'b1);

    // MPP was 3: first MRET stays in M-mode and clears MPP, second drops to U-mode
    i_mret_e = 1'b1;
    run_event(mk(64'h3000, 64'h3000, 64'd11, 64'h0, 2'b11), 0, 1'b0);
    i_mret_e = 1'b1;
    run_event(mk(64'h3000, 64'h3000, 64'd11, 64'h0, 2'b00), 0, 1'b0);

    // F-stage fault from priv 0 with an unaligned PC, then MRET back
    i_exc_valid_f = 1'b1; i_exc_code_f = 4'd1; i_pc_f = 64'h1006; i_mtvec = 64'h200;
    run_event(mk(64'h200, 64'h1006, 64'd1, 64'h1006, 2'b11), 1, 1'b0);
    i_mret_e = 1'b1;
    run_event(mk(64'h1004, 64'h1006, 64'd1, 64'h1006, 2'b00), 0, 1'b0);

    // MRET in U-mode is an illegal-instruction trap
    i_mret_e = 1'b1; i_pc_e = 64'h5008; i_mtvec = 64'h8001;
    run_event(mk(64'h8000, 64'h5008, 64'd2, 64'h0, 2'b11), 0, 1'b0);

    // F-stage code 6 takes mtval from the E address
    i_exc_valid_f = 1'b1; i_exc_code_f = 4'd6; i_pc_f = 64'h6000;
    i_addr_e = 64'h7777; i_mtvec = 64'h100;
    run_event(mk(64'h100, 64'h6000, 64'd6, 64'h7777, 2'b11), 2, 1'b0);

    // All-ones vector and PC: alignment and zero-extended cause
    i_exc_valid_e = 1'b1; i_exc_code_e = 4'd15; i_pc_e = 64'hFFFF_FFFF_FFFF_FFF0;
    i_mtvec = 64'hFFFF_FFFF_FFFF_FFFF;
    run_event(mk(64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF0, 64'd15, 64'h0, 2'b11), 0, 1'b0);

    // Asynchronous reset in REDIRECT
    i_exc_valid_e = 1'b1; i_exc_code_e = 4'd0; i_pc_e = 64'h1234; i_mtvec = 64'h8001;
    tick();
    clear_events();
    tick();
    chk("pre_reset_rv", {63'd0, o_redirect_valid}, 64'd1);
    chk("pre_reset_mcause", o_mcause, 64'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_rv", {63'd0, o_redirect_valid}, 64'd0);
    chk("async_rst_stall", {63'd0, o_stall}, 64'd0);
    chk("async_rst_flush", {63'd0, o_flush}, 64'd0);
    chk("async_rst_rpc", o_redirect_pc, 64'd0);
    chk("async_rst_priv", {62'd0, o_current_privilege}, 64'd3);
    chk("async_rst_mepc", o_mepc, 64'd0);
    chk("async_rst_mtval", o_mtval, 64'd0);
    chk("async_rst_state", {62'd0, o_dbg_state}, 64'd0);
    tick();

    // Event on the first edge after reset release
    i_rst_n = 1'b1;
    i_exc_valid_e = 1'b1; i_exc_code_e = 4'd3; i_pc_e = 64'h40;
    run_event(mk(64'h8000, 64'h40, 64'd3, 64'h0, 2'b11), 0, 1'b0);

    repeat (2) tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN_64b (2'b10): data width W = 1<<(XLEN+4).
REQ-002 SHALL have i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have i_exc_valid_f  input  1  fetch-stage exception present.
REQ-005 SHALL have i_exc_code_f  input  4  fetch-stage exception code.
REQ-006 SHALL have i_pc_f  input  W  fetch-stage PC.
REQ-007 SHALL have i_exc_valid_e  input  1  execute-stage exception present.
REQ-008 SHALL have i_exc_code_e  input  4  execute-stage exception code.
REQ-009 SHALL have i_pc_e  input  W  execute-stage PC.
REQ-010 SHALL have i_addr_e  input  W  execute-stage effective address (ALU out).
REQ-011 SHALL have i_mret_e  input  1  MRET in execute.
REQ-012 SHALL have i_mtvec  input  W  trap vector base.
REQ-013 SHALL have i_redirect_ready  input  1  fetch accepts the redirect.
REQ-014 SHALL have o_flush  output  1  flush F/D/E.
REQ-015 SHALL have o_stall  output  1  freeze the pipeline.
REQ-016 SHALL have o_redirect_valid  output  1  redirect PC valid.
REQ-017 SHALL have o_redirect_pc  output  W  redirect target.
REQ-018 SHALL have o_current_privilege  output  2  current privilege mode.
REQ-019 SHALL have o_mepc, o_mcause, o_mtval  output  W each  trap CSR values (read-only).

Function
REQ-020 SHALL implement FSM IDLE -> FLUSH -> REDIRECT -> IDLE.
REQ-021 IDLE: an event in cycle T is captured at edge T+1; FLUSH lasts exactly 1 cycle.
REQ-022 Events SHALL be, in priority order: E exception > MRET > F exception. E is older, so on a simultaneous F and E exception, E SHALL win.
REQ-023 An exception capture SHALL perform all of:
- mcause <= zero-extended code (bit W-1 = 0);
- mepc <= PC of the winning stage;
- MPP <= current privilege;
- privilege <= 2'b11.
REQ-024 MRET taken with privilege == 2'b11 SHALL perform all of:
- privilege <= MPP;
- MPP <= 2'b00;
- mepc, mcause and mtval unchanged.
REQ-025 MRET taken with privilege != 2'b11 SHALL be handled as an E exception, code 2, mepc = i_pc_e.
REQ-026 FLUSH: o_flush=1 and o_stall=1.
REQ-027 REDIRECT: o_stall=1 and o_redirect_valid=1.
- o_redirect_pc = {i_mtvec[W-1:2],2'b00} for a trap.
- o_redirect_pc = {mepc[W-1:2],2'b00} for MRET.
REQ-028 o_redirect_valid and o_redirect_pc SHALL hold stable until the cycle in which i_redirect_ready=1; the FSM SHALL leave REDIRECT for IDLE on that edge.
REQ-029 Exception and MRET inputs SHALL be ignored outside IDLE (no nesting, no queuing).
REQ-030 In IDLE, o_flush, o_stall and o_redirect_valid SHALL all be 0.
REQ-031 o_mepc, o_mcause, o_mtval and o_current_privilege SHALL be registered outputs, updated on the capture edge.

Reset
REQ-032 Assertion of i_rst_n=0 SHALL immediately force the following, including mid-FLUSH or mid-REDIRECT:
- state IDLE; privilege 2'b11; MPP 2'b00;
- mepc, mcause, mtval = 0;
- o_flush, o_stall, o_redirect_valid = 0; o_redirect_pc = 0.
REQ-033 After deassertion, the first event SHALL be accepted on the first rising edge.

Configuration
REQ-034 Macro TRAP_SEQUENCER_MTVAL_EN defined: mtval SHALL be written on trap capture as follows:
- codes 0/1: mtval <= faulting PC;
- codes 4/5/6/7: mtval <= i_addr_e;
- all other codes: mtval <= 0.
REQ-035 Macro TRAP_SEQUENCER_MTVAL_EN undefined: the mtval register SHALL be absent and o_mtval SHALL be a constant 0.

Verification
REQ-036 Test: i_exc_valid_e=1, code 4, pc_e=0x1000, addr_e=0x2003, mtvec=0x8001, priv 2'b00.
- Required: 1 cycle o_flush, then redirect to 0x8000.
- mcause=4, mepc=0x1000, mtval=0x2003 (with MTVAL_EN), priv=3.
REQ-037 Test: E code 11 and F code 0 in the same cycle.
- Required: mcause=11, mepc=pc_e, F event dropped.
REQ-038 Test: hold i_redirect_ready=0 for 5 cycles in REDIRECT, inject new exceptions.
- Required: o_redirect_pc stable, o_stall=1, no CSR change.
- Exit to IDLE on the ready cycle.
REQ-039 Test: trap from priv 0, then MRET with mepc=0x1006.
- Required: redirect to 0x1004, priv=0, MPP=0.
- Second MRET at priv 0: trap with code 2.
REQ-040 Test: assert i_rst_n=0 mid-REDIRECT.
- Required: outputs 0 and priv=3 asynchronously, before the next clock edge.
